// File: rtl/alu_seq_ctrl.sv
// Sequencer for a 4-entry, 4-bit register file driving an external ALU stage.
// A command is accepted in IDLE. An ALU command registers its operands, then
// spends one EXEC cycle waiting for the combinational ALU result, then writes
// the result back. A load writes its immediate at the accept edge. Every
// command ends in a single WB cycle, during which res_valid is high.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_sel,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs,
  input  logic [1:0] cmd_rt,
  input  logic       cmd_imm_en,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [3:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic       flag_c,
  output logic       flag_z,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [3:0][3:0] r_rf;
  logic [1:0]      r_rd;
  logic [3:0]      r_alu_x, r_alu_y, r_alu_sel, r_res_data;
  logic            r_flag_c, r_flag_z;
  logic            w_accept;

  assign w_accept  = cmd_valid && (r_state == IDLE);
  assign cmd_ready = (r_state == IDLE);
  assign res_valid = (r_state == WB);
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign alu_sel   = r_alu_sel;
  assign res_data  = r_res_data;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;
  // Read path is combinational, so a register being written shows its old value until the edge.
  assign dbg_data  = r_rf[dbg_addr];

  // State register; reset aborts any in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: a load skips EXEC because there is no ALU result to wait for.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = cmd_load ? WB : EXEC;
      EXEC: w_next = WB;
      WB:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operands are captured at accept, so aliasing rd with rs/rt cannot disturb them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rf       <= '0;
      r_rd       <= '0;
      r_alu_x    <= '0;
      r_alu_y    <= '0;
      r_alu_sel  <= '0;
      r_res_data <= '0;
      r_flag_c   <= 1'b0;
      r_flag_z   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (cmd_load) begin
            r_rf[cmd_rd] <= cmd_imm;
            r_res_data   <= cmd_imm;
            r_flag_z     <= (cmd_imm == 4'd0);
          end else begin
            r_alu_x   <= r_rf[cmd_rs];
            r_alu_y   <= cmd_imm_en ? cmd_imm : r_rf[cmd_rt];
            r_alu_sel <= cmd_sel;
            r_rd      <= cmd_rd;
          end
        end
        EXEC: begin
          r_rf[r_rd] <= alu_out;
          r_res_data <= alu_out;
          r_flag_z   <= (alu_out == 4'd0);
          // Only arithmetic codes produce a meaningful carry.
          if (!r_alu_sel[3]) r_flag_c <= alu_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a reference ALU stage closes the loop. A command
// table carries hand-derived expected results, which feed a result scoreboard.
// Short hand-written sequences cover the back-to-back, reset and abort cases.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_load, cmd_imm_en;
  logic [3:0] cmd_sel, cmd_imm;
  logic [1:0] cmd_rd, cmd_rs, cmd_rt, dbg_addr;
  logic [3:0] alu_x, alu_y, alu_sel, alu_out, res_data, dbg_data;
  logic       alu_cout, res_valid, flag_c, flag_z;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_sel(cmd_sel), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs),
    .cmd_rt(cmd_rt), .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_cout(alu_cout), .res_valid(res_valid), .res_data(res_data),
    .flag_c(flag_c), .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External ALU stage, combinational.
  logic [3:0] yop;
  logic [4:0] sum;
  always_comb begin
    yop      = (alu_y & {4{alu_sel[1]}}) | (~alu_y & {4{alu_sel[2]}});
    sum      = {1'b0, alu_x} + {1'b0, yop} + {4'b0, alu_sel[0]};
    alu_out  = sum[3:0];
    alu_cout = sum[4];
    if (alu_sel[3]) begin
      alu_cout = 1'b0;
      case (alu_sel[1:0])
        2'b00:   alu_out = alu_x & alu_y;
        2'b01:   alu_out = alu_x | alu_y;
        2'b10:   alu_out = alu_x ^ alu_y;
        default: alu_out = ~alu_x;
      endcase
    end
  end

  typedef struct {
    logic       ld;
    logic [3:0] sel;
    logic [1:0] rd, rs, rt;
    logic       ie;
    logic [3:0] imm, ex, ey, ed;
    logic       ec, ez;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       c, z;
  } res_t;

  vec_t tbl [17];
  res_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && res_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_res_valid: got res_data=%0h expected no strobe at %0t", res_data, $time);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("res_data", res_data, e.d);
        chk("flag_c", 4'(flag_c), 4'(e.c));
        chk("flag_z", 4'(flag_z), 4'(e.z));
      end
    end
  end

  task automatic drive(input vec_t v);
    cmd_load = v.ld; cmd_sel = v.sel; cmd_rd = v.rd; cmd_rs = v.rs;
    cmd_rt = v.rt; cmd_imm_en = v.ie; cmd_imm = v.imm;
  endtask

  // Offer one command from a negedge, wait for acceptance, check latency and operands.
  task automatic issue(input vec_t v, input bit push);
    int n;
    res_t e;
    drive(v);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 4'(cmd_ready), 4'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin e.d = v.ed; e.c = v.ec; e.z = v.ez; sb.push_back(e); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("ready_busy", 4'(cmd_ready), 4'd0);
    if (v.ld) begin
      chk("load_latency", 4'(res_valid), 4'd1);
    end else begin
      chk("exec_no_valid", 4'(res_valid), 4'd0);
      chk("alu_x", alu_x, v.ex);
      chk("alu_y", alu_y, v.ey);
      chk("alu_sel", alu_sel, v.sel);
      @(negedge clk);
      chk("alu_latency", 4'(res_valid), 4'd1);
    end
  endtask

  task automatic chk_reg(input logic [1:0] a, input logic [3:0] exp, input string name);
    dbg_addr = a; #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    vec_t v;
    //         ld    sel    rd    rs    rt    ie    imm    ex     ey     ed     ec    ez
    tbl[0]  = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h9, 4'h0, 4'h0, 4'h9, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 1'b0, 4'h8, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h2, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'h5, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0, 4'h9, 4'h9, 4'h0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h5, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'hA, 2'd0, 2'd0, 2'd0, 1'b1, 4'hF, 4'h5, 4'hF, 4'hA, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h6, 2'd2, 2'd2, 2'd0, 1'b0, 4'h0, 4'h8, 4'hA, 4'h7, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'h1, 2'd0, 2'd1, 2'd0, 1'b0, 4'h0, 4'h0, 4'hA, 4'h1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'h4, 2'd3, 2'd2, 2'd3, 1'b0, 4'h0, 4'h7, 4'h1, 4'h5, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'h8, 2'd1, 2'd3, 2'd2, 1'b0, 4'h0, 4'h5, 4'h7, 4'h5, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'hD, 2'd2, 2'd1, 2'd0, 1'b1, 4'h2, 4'h5, 4'h2, 4'h7, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 2'd0, 2'd1, 2'd0, 1'b0, 4'h0, 4'h5, 4'h1, 4'hA, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'h3, 2'd1, 2'd0, 2'd2, 1'b0, 4'h0, 4'hA, 4'h7, 4'h2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 4'hA, 4'hA, 4'hA, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'h7, 2'd2, 2'd3, 2'd0, 1'b0, 4'h0, 4'hA, 4'hA, 4'hA, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 4'h0, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 4'hB, 2'd0, 2'd3, 2'd0, 1'b0, 4'h0, 4'h0, 4'hA, 4'hF, 1'b1, 1'b0};

    reset_n = 1'b0; cmd_valid = 1'b0; dbg_addr = 2'd0;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    chk("rst_ready", 4'(cmd_ready), 4'd1);
    chk("rst_res_valid", 4'(res_valid), 4'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Command table.
    for (int i = 0; i < 17; i++) begin
      issue(tbl[i], 1'b1);
      @(negedge clk);
    end
    chk_reg(2'd0, 4'hF, "tbl_R0");
    chk_reg(2'd1, 4'h2, "tbl_R1");
    chk_reg(2'd2, 4'hA, "tbl_R2");
    chk_reg(2'd3, 4'h0, "tbl_R3");

    // Back-to-back with cmd_valid held: A = R0+1 (F+1 wraps to 0), B = R0 | R2.
    @(negedge clk);
    v = '{1'b0, 4'h2, 2'd0, 2'd0, 2'd0, 1'b1, 4'h1, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
    drive(v);
    sb.push_back('{4'h0, 1'b1, 1'b1});
    dbg_addr = 2'd0;
    cmd_valid = 1'b1;
    @(negedge clk);                                   // EXEC of A
    chk("b2b_exec_ready", 4'(cmd_ready), 4'd0);
    chk("b2b_alu_x", alu_x, 4'hF);
    chk("b2b_prewrite", dbg_data, 4'hF);
    v = '{1'b0, 4'h9, 2'd1, 2'd0, 2'd2, 1'b0, 4'h0, 4'h0, 4'hA, 4'hA, 1'b1, 1'b0};
    drive(v);
    sb.push_back('{4'hA, 1'b1, 1'b0});
    @(negedge clk);                                   // WB of A
    chk("b2b_wb_ready", 4'(cmd_ready), 4'd0);
    chk("b2b_postwrite", dbg_data, 4'h0);
    @(negedge clk);                                   // IDLE, B accepted at next edge
    chk("b2b_idle_ready", 4'(cmd_ready), 4'd1);
    chk("b2b_idle_valid", 4'(res_valid), 4'd0);
    @(negedge clk);                                   // EXEC of B
    cmd_valid = 1'b0;
    chk("b2b_b_ready", 4'(cmd_ready), 4'd0);
    chk("b2b_b_sel", alu_sel, 4'h9);
    chk("b2b_b_x", alu_x, 4'h0);
    chk("b2b_b_y", alu_y, 4'hA);
    @(negedge clk);                                   // WB of B
    chk("b2b_b_wb", 4'(res_valid), 4'd1);
    repeat (2) @(negedge clk);
    chk("b2b_once_ready", 4'(cmd_ready), 4'd1);
    chk("b2b_once_valid", 4'(res_valid), 4'd0);
    chk_reg(2'd1, 4'hA, "b2b_R1");

    // Mid-cycle asynchronous reset with nonzero state.
    @(negedge clk); #2;
    reset_n = 1'b0; #1;
    chk("arst_ready", 4'(cmd_ready), 4'd1);
    chk("arst_res_valid", 4'(res_valid), 4'd0);
    chk("arst_res_data", res_data, 4'h0);
    chk("arst_flag_c", 4'(flag_c), 4'd0);
    chk("arst_flag_z", 4'(flag_z), 4'd0);
    chk("arst_alu_x", alu_x, 4'h0);
    chk("arst_alu_y", alu_y, 4'h0);
    chk("arst_alu_sel", alu_sel, 4'h0);
    for (int a = 0; a < 4; a++) chk_reg(2'(a), 4'h0, "arst_reg");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during EXEC of an ADD into R3 aborts it.
    issue('{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h3, 4'h0, 4'h0, 4'h3, 1'b0, 1'b0}, 1'b1);
    @(negedge clk);
    issue('{1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0, 1'b0}, 1'b1);
    @(negedge clk);
    v = '{1'b0, 4'h2, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0};
    drive(v);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec_x", alu_x, 4'h3);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_ready", 4'(cmd_ready), 4'd1);
    chk_reg(2'd3, 4'h0, "abort_R3");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 4'(res_valid), 4'd0);
    end
    issue('{1'b1, 4'h0, 2'd3, 2'd0, 2'd0, 1'b0, 4'h6, 4'h0, 4'h0, 4'h6, 1'b0, 1'b0}, 1'b1);
    @(negedge clk);
    chk_reg(2'd3, 4'h6, "abort_after_R3");

    repeat (2) @(negedge clk);
    chk("sb_drained", 4'(sb.size()), 4'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 cmd_valid  in  1  command offered; cmd_ready  out  1  block can accept.
REQ-004 cmd_load  in  1  1 = load immediate into rd, 0 = ALU operation.
REQ-005 cmd_sel  in  4  ALU select code, passed to alu_sel.
REQ-006 cmd_rd / cmd_rs / cmd_rt  in  2 each  destination, x-source, y-source register indices.
REQ-007 cmd_imm_en  in  1  y operand from cmd_imm instead of R[rt]; cmd_imm  in  4  immediate.
REQ-008 alu_x, alu_y  out  4  registered operands to the ALU stage; alu_sel  out  4  registered select.
REQ-009 alu_out  in  4, alu_cout  in  1  combinational result and carry from the ALU stage.
REQ-010 res_valid  out  1  one-cycle result strobe; res_data  out  4  last written value.
REQ-011 flag_c  out  1  carry flag; flag_z  out  1  zero flag.
REQ-012 dbg_addr  in  2, dbg_data  out  4  combinational read of R[dbg_addr].

Function
REQ-013 Register file SHALL be four 4-bit registers R0..R3, all writable, no hardwired zero.
REQ-014 FSM states SHALL be IDLE, EXEC, WB; cmd_ready SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted on a rising edge with cmd_valid=1 and state IDLE; cmd_valid while busy is ignored and must be held by the source.
REQ-016 ALU accept (cmd_load=0): at accept edge alu_x<=R[rs], alu_y<=(cmd_imm_en ? cmd_imm : R[rt]), alu_sel<=cmd_sel, rd latched, state->EXEC.
REQ-017 EXEC: alu_x/alu_y/alu_sel stable for the full cycle; at next edge R[rd]<=alu_out, res_data<=alu_out, flag updates, state->WB.
REQ-018 Load accept (cmd_load=1): at accept edge R[rd]<=cmd_imm, res_data<=cmd_imm, flag_z updated, state->WB directly; alu_* unchanged.
REQ-019 WB: res_valid=1 for exactly this cycle; next edge state->IDLE.
REQ-020 Latency: ALU command accepted at edge N -> res_valid high between edges N+1 and N+2; load -> res_valid high between N and N+1; throughput one ALU command per 3 cycles, one load per 2.
REQ-021 ALU codes (cmd_sel[3]=0, arithmetic, x + yop + sel[0], yop = (y&sel[1])|(~y&sel[2])): 000 x, 001 x+1, 010 x+y, 011 x+y+1, 100 x+~y, 101 x-y, 110 x-1, 111 x; results modulo 16.
REQ-022 Logic codes (cmd_sel[3]=1, sel[1:0]): 00 AND, 01 OR, 10 XOR, 11 NOT x; sel[2] ignored.
REQ-023 flag_c SHALL take alu_cout only for arithmetic commands; logic and load commands leave it unchanged.
REQ-024 flag_z SHALL be 1 iff the value written is 0, updated on every command.
REQ-025 rs, rt, rd may alias; operands are sampled at accept, so R[rd] writeback never alters the in-flight operands.
REQ-026 dbg_data SHALL show pre-write contents during the cycle ending in the write edge.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state IDLE, R0..R3=0, alu_x=alu_y=alu_sel=0, res_data=0, res_valid=0, flag_c=0, flag_z=0.
REQ-028 Reset in EXEC or WB SHALL abort the command with no writeback and no res_valid; cmd_ready=1 in the first cycle after deassertion.

Verification
REQ-029 Reset: assert reset_n=0 mid-clock -> all outputs zero at once, cmd_ready=1.
REQ-030 Load R1=9, R2=8; then ALU cmd sel=0010 rd=3 rs=1 rt=2 -> alu_x=9, alu_y=8, alu_sel=0010 in EXEC; res_data=1, flag_c=1, flag_z=0, R3=1, res_valid 1 cycle after EXEC.
REQ-031 With R1=9, sel=0101 rd=1 rs=1 rt=1 -> R1=0, flag_z=1, flag_c=1.
REQ-032 With R0=5, flag_c=1: sel=1010, cmd_imm_en=1, imm=F, rd=0 rs=0 -> R0=A, flag_c stays 1, flag_z=0.
REQ-033 Two commands with cmd_valid held continuously -> second accepted only on the first IDLE edge after WB, exactly once; cmd_ready=0 in EXEC and WB.
REQ-034 Reset pulse during EXEC of ADD into R3 -> no res_valid, R3=0, next command accepted normally.
